// File: rtl/binary_to_onehot_buf_pkg.sv
// rtl/binary_to_onehot_buf_pkg.sv - shared encoder/decoder widths, typedefs and buffer FSM states
package binary_to_onehot_buf_pkg;

  localparam int STATE_W = 8;
  localparam int BIN_W   = $clog2(STATE_W);

  typedef logic [STATE_W-1:0] onehot_t;
  typedef logic [BIN_W-1:0]   bin_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_e;

endpackage

// File: rtl/binary_to_onehot_buf_bin_decode.sv
// rtl/binary_to_onehot_buf_bin_decode.sv - combinational index to one-hot decode with range check
module bin_decode #(
  parameter int STATE_W = binary_to_onehot_buf_pkg::STATE_W,
  parameter int BIN_W   = binary_to_onehot_buf_pkg::BIN_W
) (
  input  logic [BIN_W-1:0]   bin,
  output logic [STATE_W-1:0] onehot,
  output logic               err
);

  localparam int unsigned STATE_W_U = STATE_W;

  // Widen before comparing so a full-range index does not fold to a constant compare.
  logic [31:0] idx;

  always_comb begin
    idx    = 32'(bin);
    err    = (idx >= STATE_W_U);
    onehot = '0;
    for (int i = 0; i < STATE_W; i++) begin
      onehot[i] = !err && (idx == 32'(i));
    end
  end

endmodule

// File: rtl/binary_to_onehot_buf.sv
// rtl/binary_to_onehot_buf.sv - registered binary-to-one-hot decoder with a two-entry skid buffer
module binary_to_onehot_buf
  import binary_to_onehot_buf_pkg::buf_state_e,
         binary_to_onehot_buf_pkg::EMPTY,
         binary_to_onehot_buf_pkg::ONE,
         binary_to_onehot_buf_pkg::TWO;
#(
  parameter int STATE_W = binary_to_onehot_buf_pkg::STATE_W,
  parameter int BIN_W   = $clog2(STATE_W)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [BIN_W-1:0]   bin_i,
  input  logic               bin_valid_i,
  output logic               bin_ready_o,
  output logic [STATE_W-1:0] onehot_o,
  output logic               err_o,
  output logic               valid_o,
  input  logic               ready_i
);

  buf_state_e         state_q, state_d;
  logic [STATE_W-1:0] main_q, skid_q, dec_onehot;
  logic               main_err_q, skid_err_q, dec_err;
  logic               accept, consume;
  logic               load_main_in, load_skid, load_main_skid;

  bin_decode #(.STATE_W(STATE_W), .BIN_W(BIN_W)) u_bin_decode (
    .bin    (bin_i),
    .onehot (dec_onehot),
    .err    (dec_err)
  );

  // Handshake outputs come from the state register only, so ready_i never reaches bin_ready_o.
  assign bin_ready_o = (state_q != TWO);
  assign valid_o     = (state_q != EMPTY);
  assign onehot_o    = main_q;
  assign err_o       = main_err_q;
  assign accept      = bin_valid_i && bin_ready_o;
  assign consume     = valid_o && ready_i;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_skid      = 1'b0;
    load_main_skid = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          load_main_in = 1'b1;
          state_d      = ONE;
        end
      end
      ONE: begin
        if (accept && consume) begin
          load_main_in = 1'b1;
        end else if (consume) begin
          state_d = EMPTY;
        end else if (accept) begin
          load_skid = 1'b1;
          state_d   = TWO;
        end
      end
      TWO: begin
        if (consume) begin
          load_main_skid = 1'b1;
          state_d        = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      main_err_q <= 1'b0;
      skid_q     <= '0;
      skid_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_main_in) begin
        main_q     <= dec_onehot;
        main_err_q <= dec_err;
      end else if (load_main_skid) begin
        main_q     <= skid_q;
        main_err_q <= skid_err_q;
      end
      if (load_skid) begin
        skid_q     <= dec_onehot;
        skid_err_q <= dec_err;
      end
    end
  end

endmodule
